// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift-add or restoring shift-subtract step per cycle.
// Optional MTHI/MTLO write ports are enabled by defining MULDIV_HILO_WR_EN.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
`ifdef MULDIV_HILO_WR_EN
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
`endif
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_fix;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  // prod_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};

    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_sub[WIDTH];
    div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};

    mul_fix   = neg_q ? -prod_q : prod_q;
    quo       = prod_q[WIDTH-1:0];
    rem       = prod_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi = mul_fix[2*WIDTH-1:WIDTH];
      fix_lo = mul_fix[WIDTH-1:0];
    end else if (div0_q) begin
      // the dividend magnitude never left the low half, so restoring its sign gives back a
      fix_hi = rem_neg_q ? -quo : quo;
      fix_lo = '1;
    end else begin
      fix_hi = rem_neg_q ? -rem : rem;
      fix_lo = neg_q ? -quo : quo;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          is_div_d  = op[1];
          neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d = signed_op && op[1] && a[WIDTH-1];
          div0_d    = op[1] && (b == '0);
          opnd_d    = op[1] ? b_mag : a_mag;
          prod_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d     = '0;
          state_d   = (op[1] && (b == '0)) ? FIX : RUN;
        end
`ifdef MULDIV_HILO_WR_EN
        if (we_hi) hi_d = wd;
        if (we_lo) lo_d = wd;
`endif
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          prod_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_HILO_WR_EN
  assign stall = busy_q & (start | rd_hilo | we_hi | we_lo);
`else
  assign stall = busy_q & (start | rd_hilo);
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: fixed vectors, hand-written flush/reset/stall sequences,
// and random ops checked against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush, rd_hilo;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_HILO_WR_EN
  logic         we_hi = 1'b0;
  logic         we_lo = 1'b0;
  logic [W-1:0] wd = '0;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .rd_hilo (rd_hilo),
`ifdef MULDIV_HILO_WR_EN
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .wd      (wd),
`endif
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_cyc;
  } vec_t;

  vec_t vecs[11];

  // step to just after the next rising edge, so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference results straight from MIPS arithmetic on wide integers
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] mhi, output logic [W-1:0] mlo, output int mcyc);
    longint       sa, sb, sq, sr;
    logic [63:0]  p;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    mcyc = W + 2;
    case (mop)
      2'b00: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      2'b01: begin p = {32'b0, ma} * {32'b0, mb}; mhi = p[63:32]; mlo = p[31:0]; end
      2'b10: begin
        if (mb == '0) begin mhi = ma; mlo = '1; mcyc = 2; end
        else begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); mlo = p[31:0];
          p = 64'(sr); mhi = p[31:0];
        end
      end
      default: begin
        if (mb == '0) begin mhi = ma; mlo = '1; mcyc = 2; end
        else begin mlo = ma / mb; mhi = ma % mb; end
      end
    endcase
  endfunction

  // starts an op in the current cycle and follows it to done (bounded)
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int done_cyc, output int busy_cnt, output logic moved);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    done_cyc = -1; busy_cnt = 0; moved = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cyc = c; break; end
      if (hi !== h0 || lo !== l0) moved = 1'b1;
    end
  endtask

  task automatic runCheck(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int ecyc);
    int   dc, bc;
    logic mv;
    applyStimulus(o, x, y, dc, bc, mv);
    checkOutput({name, " done_cycle"}, 64'(dc), 64'(ecyc));
    checkOutput({name, " busy_cycles"}, 64'(bc), 64'(ecyc - 1));
    checkOutput({name, " hilo_early"}, 64'(mv), 64'(0));
    checkOutput({name, " hi"}, 64'(hi), 64'(eh));
    checkOutput({name, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int           cyc, seen_done;
    logic [W-1:0] rh, rl, ra, rb;
    logic [1:0]   rop;
    int           rc;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[3]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 2};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 2};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
    vecs[7]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
    vecs[9]  = '{2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 34};
    vecs[10] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};

    reset = 1'b1; start = 1'b0; flush = 1'b0; rd_hilo = 1'b0;
    op = 2'b00; a = '0; b = '0;
    tick(); tick();
    rd_hilo = 1'b1; start = 1'b1;
    #1;
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset stall", 64'(stall), 64'(0));
    checkOutput("reset hi", 64'(hi), 64'(0));
    checkOutput("reset lo", 64'(lo), 64'(0));
    rd_hilo = 1'b0; start = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++)
      runCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);
    tick();
    checkOutput("done one-cycle pulse", 64'(done), 64'(0));

    // start while busy is ignored and stalls; the first op completes unaffected
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    tick(); start = 1'b0;
    repeat (4) tick();
    rd_hilo = 1'b1; start = 1'b1; op = 2'b11; a = 32'h5; b = 32'h1;
    #1;
    checkOutput("stall start+rd_hilo", 64'(stall), 64'(1));
    tick();
    rd_hilo = 1'b0; start = 1'b0;
    #1;
    checkOutput("stall no request", 64'(stall), 64'(0));
    rd_hilo = 1'b1;
    #1;
    checkOutput("stall rd_hilo only", 64'(stall), 64'(1));
    rd_hilo = 1'b0;
    cyc = 6;
    while (!done && cyc < 200) begin tick(); cyc++; end
    checkOutput("stalled op done_cycle", 64'(cyc), 64'(34));
    checkOutput("stalled op hi", 64'(hi), 64'(32'hFFFFFFFE));
    checkOutput("stalled op lo", 64'(lo), 64'(32'h00000001));
    rd_hilo = 1'b1;
    #1;
    checkOutput("no stall in done", 64'(stall), 64'(0));
    rd_hilo = 1'b0;
    tick();
    checkOutput("idle after done busy", 64'(busy), 64'(0));

    // flush mid-op: hi/lo keep their pre-op values and no done appears
    runCheck("prep 11/22", 2'b11, 32'h00002211, 32'h00000100, 32'h11, 32'h22, 34);
    start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h5678;
    tick(); start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'(0));
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen_done++;
      tick();
    end
    checkOutput("flush no done", 64'(seen_done), 64'(0));
    checkOutput("flush hi kept", 64'(hi), 64'(32'h11));
    checkOutput("flush lo kept", 64'(lo), 64'(32'h22));
    flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'h3; b = 32'h3;
    tick(); flush = 1'b0; start = 1'b0;
    checkOutput("flush blocks start", 64'(busy), 64'(0));

    // reset in the middle of a divide, then a normal op
    start = 1'b1; op = 2'b10; a = 32'hFFFFFF9C; b = 32'h7;
    tick(); start = 1'b0;
    repeat (19) tick();
    checkOutput("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick(); reset = 1'b0;
    checkOutput("midop reset busy", 64'(busy), 64'(0));
    checkOutput("midop reset done", 64'(done), 64'(0));
    checkOutput("midop reset hi", 64'(hi), 64'(0));
    checkOutput("midop reset lo", 64'(lo), 64'(0));
    runCheck("after reset", 2'b10, 32'hFFFFFF9C, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFF2, 34);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, rh, rl, rc);
      runCheck($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rh, rl, rc);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
